// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - framing bytes, type codes and state encoding shared by the UART frame TX/RX
package uart_frame_pkg;

    // Start-of-frame marker "ST"
    localparam logic [7:0] ST_S  = 8'h53;
    localparam logic [7:0] ST_T  = 8'h54;

    // End-of-frame marker "END"
    localparam logic [7:0] END_E = 8'h45;
    localparam logic [7:0] END_N = 8'h4E;
    localparam logic [7:0] END_D = 8'h44;

    // Frame type codes understood by the receive-side flag logic
    localparam logic [7:0] TYPE_CLR = 8'h00;
    localparam logic [7:0] TYPE_SET = 8'h01;

    typedef enum logic [3:0] {
        FS_IDLE   = 4'd0,
        FS_STROBE = 4'd1,
        FS_WAIT   = 4'd2,
        FS_NEXT   = 4'd3
    } frame_state_e;

endpackage

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - builds 'S','T',type,payload,'E','N','D' frames and feeds them to a byte-level uart_tx
//
// Ports:
//   i_Clk, i_Rst        clock, synchronous active-high reset
//   i_Send              one-cycle frame request (accepted only while idle)
//   i_Type, i_Payload   frame type byte and payload (MSB byte sent first), latched on accept
//   o_TX_DV, o_TX_Byte  byte strobe and data to uart_tx; byte held between strobes
//   i_TX_Done           per-byte completion pulse from uart_tx
//   o_Busy              frame in progress
//   o_Frame_Done        pulse when the final 'D' is acknowledged
//   o_Error             pulse when uart_tx fails to acknowledge within DONE_TIMEOUT clocks
//   o_Send_Drop         pulse when a request arrives while busy
//   o_State             current FSM state for debug
module uart_tx_frame
    import uart_frame_pkg::*;
#(
    parameter int PAYLOAD_BYTES = 4,
    parameter int DONE_TIMEOUT  = 65535
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst,
    input  logic                       i_Send,
    input  logic [7:0]                 i_Type,
    input  logic [8*PAYLOAD_BYTES-1:0] i_Payload,
    output logic                       o_TX_DV,
    output logic [7:0]                 o_TX_Byte,
    input  logic                       i_TX_Done,
    output logic                       o_Busy,
    output logic                       o_Frame_Done,
    output logic                       o_Error,
    output logic                       o_Send_Drop,
    output logic [3:0]                 o_State
);

    localparam int FRAME_LEN = PAYLOAD_BYTES + 6;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int CNT_W     = $clog2(DONE_TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(FRAME_LEN - 1);
    // The compare uses the pre-increment value, so the abort fires on the
    // DONE_TIMEOUT-th WAIT cycle.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(DONE_TIMEOUT - 1);

    frame_state_e               state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [7:0]                 type_q, type_d;
    logic [8*PAYLOAD_BYTES-1:0] payload_q, payload_d;
    logic [7:0]                 tx_byte_q, tx_byte_d;
    logic                       tx_dv_q, tx_dv_d;
    logic                       busy_q, busy_d;
    logic                       frame_done_q, frame_done_d;
    logic                       error_q, error_d;
    logic                       drop_q, drop_d;

    logic [7:0]                 cur_byte;
    int                         k;

    // Byte selection for frame position idx_q
    always_comb begin
        cur_byte = 8'h00;
        k        = int'(idx_q);
        if (k == 0) begin
            cur_byte = ST_S;
        end else if (k == 1) begin
            cur_byte = ST_T;
        end else if (k == 2) begin
            cur_byte = type_q;
        end else if (k < 3 + PAYLOAD_BYTES) begin
            cur_byte = payload_q[8*(PAYLOAD_BYTES - 1 - (k - 3)) +: 8];
        end else if (k == FRAME_LEN - 3) begin
            cur_byte = END_E;
        end else if (k == FRAME_LEN - 2) begin
            cur_byte = END_N;
        end else begin
            cur_byte = END_D;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        type_d       = type_q;
        payload_d    = payload_q;
        tx_byte_d    = tx_byte_q;
        tx_dv_d      = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        error_d      = 1'b0;
        // busy_q is high exactly when the FSM is outside IDLE
        drop_d       = i_Send & busy_q;

        unique case (state_q)
            FS_IDLE: begin
                if (i_Send) begin
                    type_d    = i_Type;
                    payload_d = i_Payload;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = FS_STROBE;
                end
            end
            FS_STROBE: begin
                tx_dv_d   = 1'b1;
                tx_byte_d = cur_byte;
                cnt_d     = '0;
                state_d   = FS_WAIT;
            end
            FS_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // An acknowledge on the timeout cycle still counts
                if (i_TX_Done) begin
                    state_d = FS_NEXT;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FS_IDLE;
                end
            end
            FS_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = FS_IDLE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = FS_STROBE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = FS_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q      <= FS_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            type_q       <= 8'h00;
            payload_q    <= '0;
            tx_byte_q    <= 8'h00;
            tx_dv_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            error_q      <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            type_q       <= type_d;
            payload_q    <= payload_d;
            tx_byte_q    <= tx_byte_d;
            tx_dv_q      <= tx_dv_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            error_q      <= error_d;
            drop_q       <= drop_d;
        end
    end

    assign o_TX_DV      = tx_dv_q;
    assign o_TX_Byte    = tx_byte_q;
    assign o_Busy       = busy_q;
    assign o_Frame_Done = frame_done_q;
    assign o_Error      = error_q;
    assign o_Send_Drop  = drop_q;
    assign o_State      = state_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - self-checking bench for uart_tx_frame with a reactive uart_tx model
module tb_uart_tx_frame;

    localparam int PB  = 4;
    localparam int TO  = 20;
    localparam int NF  = PB + 6;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_Send = 1'b0;
    logic [7:0]      i_Type = 8'h00;
    logic [8*PB-1:0] i_Payload = '0;
    logic            i_TX_Done = 1'b0;
    logic            o_TX_DV, o_Busy, o_Frame_Done, o_Error, o_Send_Drop;
    logic [7:0]      o_TX_Byte;
    logic [3:0]      o_State;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // uart_tx model controls (written only by the stimulus process)
    int ack_delay  = 10;
    bit rand_ack   = 1'b0;
    int no_ack_idx = -1;
    int frame_base = 0;

    // Observations (written only by the monitor process)
    int         ack_rem = 0;
    logic [7:0] dv_q[$];
    int         dv_cyc[$];
    int         done_cyc[$];
    int         err_cyc[$];
    int         drop_cyc[$];

    uart_tx_frame #(.PAYLOAD_BYTES(PB), .DONE_TIMEOUT(TO)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Send(i_Send), .i_Type(i_Type), .i_Payload(i_Payload),
        .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte), .i_TX_Done(i_TX_Done), .o_Busy(o_Busy),
        .o_Frame_Done(o_Frame_Done), .o_Error(o_Error), .o_Send_Drop(o_Send_Drop), .o_State(o_State)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx model: acknowledges a strobe ack_delay cycles later; also records every pulse
    always @(posedge clk) begin
        #1;
        if (ack_rem > 0) begin
            ack_rem   = ack_rem - 1;
            i_TX_Done = (ack_rem == 0);
        end else begin
            i_TX_Done = 1'b0;
        end
        if (o_TX_DV === 1'b1) begin
            if (no_ack_idx != dv_q.size() - frame_base)
                ack_rem = rand_ack ? int'($urandom_range(19, 1)) : ack_delay;
            dv_q.push_back(o_TX_Byte);
            dv_cyc.push_back(cyc);
        end
        if (o_Frame_Done === 1'b1) done_cyc.push_back(cyc);
        if (o_Error === 1'b1)      err_cyc.push_back(cyc);
        if (o_Send_Drop === 1'b1)  drop_cyc.push_back(cyc);
    end

    // Reference frame: marker bytes, type, payload most-significant byte first, end marker
    task automatic build_frame(input logic [7:0] t, input logic [8*PB-1:0] p, output logic [7:0] f[NF]);
        f[0] = 8'h53;
        f[1] = 8'h54;
        f[2] = t;
        for (int i = 0; i < PB; i++) f[3+i] = 8'(p >> (8 * (PB - 1 - i)));
        f[NF-3] = 8'h45;
        f[NF-2] = 8'h4E;
        f[NF-1] = 8'h44;
    endtask

    // Called at a falling edge; drives a one-cycle request and scrambles the data afterwards
    task automatic do_send(input logic [7:0] t, input logic [8*PB-1:0] p, output int t_cyc);
        i_Send    = 1'b1;
        i_Type    = t;
        i_Payload = p;
        t_cyc     = cyc;
        @(negedge clk);
        i_Send    = 1'b0;
        i_Type    = 8'($urandom);
        i_Payload = $urandom;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_Busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (o_TX_DV !== 1'b0)      begin errors++; $display("FAIL reset_dv: got %b want 0", o_TX_DV); end
        checks++; if (o_TX_Byte !== 8'h00)   begin errors++; $display("FAIL reset_byte: got %h want 00", o_TX_Byte); end
        checks++; if (o_Busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", o_Busy); end
        checks++; if (o_Frame_Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", o_Frame_Done); end
        checks++; if (o_Error !== 1'b0)      begin errors++; $display("FAIL reset_err: got %b want 0", o_Error); end
        checks++; if (o_Send_Drop !== 1'b0)  begin errors++; $display("FAIL reset_drop: got %b want 0", o_Send_Drop); end
        checks++; if (o_State !== 4'd0)      begin errors++; $display("FAIL reset_state: got %0d want 0", o_State); end
    endtask

    task automatic test_basic();
        logic [7:0] f[NF];
        int t, b, d0, e0;
        bit ok;
        ack_delay = 10; rand_ack = 1'b0; no_ack_idx = -1;
        b = dv_q.size(); d0 = done_cyc.size(); e0 = err_cyc.size();
        frame_base = b;
        build_frame(8'h01, 32'h12345678, f);
        do_send(8'h01, 32'h12345678, t);
        wait_idle(400, ok);
        repeat (2) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL basic_idle: busy never dropped, required within 400 cycles"); end
        checks++; if (dv_q.size() - b !== NF) begin errors++; $display("FAIL basic_dv_count: got %0d want %0d", dv_q.size() - b, NF); end
        if (dv_q.size() - b >= NF) begin
            for (int i = 0; i < NF; i++) begin
                checks++; if (dv_q[b+i] !== f[i]) begin errors++; $display("FAIL basic_byte%0d: got %h want %h", i, dv_q[b+i], f[i]); end
            end
            checks++; if (dv_cyc[b] !== t + 2) begin errors++; $display("FAIL basic_first_dv: got cycle %0d want %0d", dv_cyc[b], t + 2); end
            for (int i = 1; i < NF; i++) begin
                checks++; if (dv_cyc[b+i] - dv_cyc[b+i-1] !== 13) begin errors++; $display("FAIL basic_spacing%0d: got %0d want 13", i, dv_cyc[b+i] - dv_cyc[b+i-1]); end
            end
            checks++; if (done_cyc.size() - d0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cyc.size() - d0); end
            else begin
                checks++; if (done_cyc[d0] !== dv_cyc[b+NF-1] + 12) begin errors++; $display("FAIL basic_done_time: got %0d want %0d", done_cyc[d0], dv_cyc[b+NF-1] + 12); end
            end
        end
        checks++; if (err_cyc.size() !== e0) begin errors++; $display("FAIL basic_err: got %0d pulses want 0", err_cyc.size() - e0); end
        checks++; if (o_Busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", o_Busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] f1[NF], f2[NF];
        logic [31:0] p1, p2;
        int t1, t2, b, dr0, d0;
        bit ok;
        ack_delay = 10; rand_ack = 1'b0; no_ack_idx = -1;
        p1 = $urandom; p2 = $urandom;
        build_frame(8'h01, p1, f1);
        build_frame(8'h00, p2, f2);
        b = dv_q.size(); dr0 = drop_cyc.size(); d0 = done_cyc.size();
        frame_base = b;
        do_send(8'h01, p1, t1);
        wait_idle(400, ok);
        frame_base = b + NF;
        do_send(8'h00, p2, t2);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_idle1: busy never dropped, required within 400 cycles"); end
        wait_idle(400, ok);
        repeat (2) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_idle2: busy never dropped, required within 400 cycles"); end
        checks++; if (dv_q.size() - b !== 2 * NF) begin errors++; $display("FAIL b2b_dv_count: got %0d want %0d", dv_q.size() - b, 2 * NF); end
        if (dv_q.size() - b >= 2 * NF) begin
            for (int i = 0; i < NF; i++) begin
                checks++; if (dv_q[b+i] !== f1[i]) begin errors++; $display("FAIL b2b_f1_byte%0d: got %h want %h", i, dv_q[b+i], f1[i]); end
                checks++; if (dv_q[b+NF+i] !== f2[i]) begin errors++; $display("FAIL b2b_f2_byte%0d: got %h want %h", i, dv_q[b+NF+i], f2[i]); end
            end
            checks++; if (dv_cyc[b+NF] !== t2 + 2) begin errors++; $display("FAIL b2b_second_dv: got cycle %0d want %0d", dv_cyc[b+NF], t2 + 2); end
            checks++; if (t2 !== dv_cyc[b+NF-1] + 12) begin errors++; $display("FAIL b2b_accept_time: send at %0d want %0d", t2, dv_cyc[b+NF-1] + 12); end
        end
        checks++; if (drop_cyc.size() !== dr0) begin errors++; $display("FAIL b2b_drop: got %0d pulses want 0", drop_cyc.size() - dr0); end
        checks++; if (done_cyc.size() - d0 !== 2) begin errors++; $display("FAIL b2b_done: got %0d want 2", done_cyc.size() - d0); end
    endtask

    task automatic test_drop();
        logic [7:0] f[NF];
        int t, td, b, dr0, d0;
        bit ok;
        ack_delay = 10; rand_ack = 1'b0; no_ack_idx = -1;
        build_frame(8'h01, 32'h12345678, f);
        b = dv_q.size(); dr0 = drop_cyc.size(); d0 = done_cyc.size();
        frame_base = b;
        do_send(8'h01, 32'h12345678, t);
        repeat (2) @(negedge clk);
        do_send(8'hAA, 32'hFFFFFFFF, td);
        wait_idle(400, ok);
        repeat (2) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL drop_idle: busy never dropped, required within 400 cycles"); end
        checks++; if (drop_cyc.size() - dr0 !== 1) begin errors++; $display("FAIL drop_count: got %0d want 1", drop_cyc.size() - dr0); end
        else begin
            checks++; if (drop_cyc[dr0] !== td + 1) begin errors++; $display("FAIL drop_time: got %0d want %0d", drop_cyc[dr0], td + 1); end
        end
        checks++; if (dv_q.size() - b !== NF) begin errors++; $display("FAIL drop_dv_count: got %0d want %0d", dv_q.size() - b, NF); end
        else begin
            for (int i = 0; i < NF; i++) begin
                checks++; if (dv_q[b+i] !== f[i]) begin errors++; $display("FAIL drop_byte%0d: got %h want %h", i, dv_q[b+i], f[i]); end
            end
        end
        checks++; if (done_cyc.size() - d0 !== 1) begin errors++; $display("FAIL drop_done: got %0d want 1", done_cyc.size() - d0); end
    endtask

    task automatic test_timeout();
        logic [7:0] f[NF];
        logic [7:0] ty;
        logic [31:0] p;
        int t, b, e0, d0;
        bit ok;
        ack_delay = 10; rand_ack = 1'b0; no_ack_idx = 3;
        ty = 8'($urandom); p = $urandom;
        build_frame(ty, p, f);
        b = dv_q.size(); e0 = err_cyc.size(); d0 = done_cyc.size();
        frame_base = b;
        do_send(ty, p, t);
        wait_idle(400, ok);
        repeat (2) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL to_idle: busy never dropped, required within 400 cycles"); end
        checks++; if (dv_q.size() - b !== 4) begin errors++; $display("FAIL to_dv_count: got %0d want 4", dv_q.size() - b); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (dv_q[b+i] !== f[i]) begin errors++; $display("FAIL to_byte%0d: got %h want %h", i, dv_q[b+i], f[i]); end
            end
            checks++; if (err_cyc.size() - e0 !== 1) begin errors++; $display("FAIL to_err_count: got %0d want 1", err_cyc.size() - e0); end
            else begin
                checks++; if (err_cyc[e0] !== dv_cyc[b+3] + TO) begin errors++; $display("FAIL to_err_time: got %0d want %0d", err_cyc[e0], dv_cyc[b+3] + TO); end
            end
        end
        checks++; if (done_cyc.size() !== d0) begin errors++; $display("FAIL to_done: got %0d pulses want 0", done_cyc.size() - d0); end
        checks++; if (o_Busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b want 0", o_Busy); end

        no_ack_idx = -1;
        ty = 8'($urandom); p = $urandom;
        build_frame(ty, p, f);
        b = dv_q.size(); e0 = err_cyc.size(); d0 = done_cyc.size();
        frame_base = b;
        do_send(ty, p, t);
        wait_idle(400, ok);
        repeat (2) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL to_clean_idle: busy never dropped, required within 400 cycles"); end
        checks++; if (dv_q.size() - b !== NF) begin errors++; $display("FAIL to_clean_count: got %0d want %0d", dv_q.size() - b, NF); end
        else begin
            for (int i = 0; i < NF; i++) begin
                checks++; if (dv_q[b+i] !== f[i]) begin errors++; $display("FAIL to_clean_byte%0d: got %h want %h", i, dv_q[b+i], f[i]); end
            end
        end
        checks++; if (done_cyc.size() - d0 !== 1) begin errors++; $display("FAIL to_clean_done: got %0d want 1", done_cyc.size() - d0); end
        checks++; if (err_cyc.size() !== e0) begin errors++; $display("FAIL to_clean_err: got %0d pulses want 0", err_cyc.size() - e0); end
    endtask

    task automatic test_reset_mid();
        int t, b, d0, e0, dr0;
        bit seen;
        ack_delay = 10; rand_ack = 1'b0; no_ack_idx = -1;
        b = dv_q.size(); d0 = done_cyc.size(); e0 = err_cyc.size(); dr0 = drop_cyc.size();
        frame_base = b;
        do_send(8'h01, $urandom, t);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (dv_q.size() - b >= 5) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL rstmid_reach: payload byte 2 never strobed within 200 cycles"); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (o_TX_DV !== 1'b0)      begin errors++; $display("FAIL rstmid_dv: got %b want 0", o_TX_DV); end
        checks++; if (o_TX_Byte !== 8'h00)   begin errors++; $display("FAIL rstmid_byte: got %h want 00", o_TX_Byte); end
        checks++; if (o_Busy !== 1'b0)       begin errors++; $display("FAIL rstmid_busy: got %b want 0", o_Busy); end
        checks++; if (o_State !== 4'd0)      begin errors++; $display("FAIL rstmid_state: got %0d want 0", o_State); end
        checks++; if (o_Frame_Done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", o_Frame_Done); end
        checks++; if (o_Error !== 1'b0)      begin errors++; $display("FAIL rstmid_err: got %b want 0", o_Error); end
        checks++; if (o_Send_Drop !== 1'b0)  begin errors++; $display("FAIL rstmid_drop: got %b want 0", o_Send_Drop); end
        // The model's pending acknowledge lands while idle and must be ignored
        repeat (40) @(negedge clk);
        checks++; if (dv_q.size() - b !== 5) begin errors++; $display("FAIL rstmid_no_dv: got %0d strobes want 5", dv_q.size() - b); end
        checks++; if (done_cyc.size() !== d0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cyc.size() - d0); end
        checks++; if (err_cyc.size() !== e0) begin errors++; $display("FAIL rstmid_no_err: got %0d pulses want 0", err_cyc.size() - e0); end
        checks++; if (drop_cyc.size() !== dr0) begin errors++; $display("FAIL rstmid_no_drop: got %0d pulses want 0", drop_cyc.size() - dr0); end
        checks++; if (o_State !== 4'd0) begin errors++; $display("FAIL rstmid_idle: got %0d want 0", o_State); end
    endtask

    task automatic test_tie();
        logic [7:0] f[NF];
        logic [31:0] p;
        int t, b, d0, e0;
        bit ok;
        ack_delay = TO - 1; rand_ack = 1'b0; no_ack_idx = -1;
        p = $urandom;
        build_frame(8'h01, p, f);
        b = dv_q.size(); d0 = done_cyc.size(); e0 = err_cyc.size();
        frame_base = b;
        do_send(8'h01, p, t);
        wait_idle(600, ok);
        repeat (2) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL tie_idle: busy never dropped, required within 600 cycles"); end
        checks++; if (err_cyc.size() !== e0) begin errors++; $display("FAIL tie_err: got %0d pulses want 0", err_cyc.size() - e0); end
        checks++; if (done_cyc.size() - d0 !== 1) begin errors++; $display("FAIL tie_done: got %0d want 1", done_cyc.size() - d0); end
        checks++; if (dv_q.size() - b !== NF) begin errors++; $display("FAIL tie_dv_count: got %0d want %0d", dv_q.size() - b, NF); end
        else begin
            for (int i = 0; i < NF; i++) begin
                checks++; if (dv_q[b+i] !== f[i]) begin errors++; $display("FAIL tie_byte%0d: got %h want %h", i, dv_q[b+i], f[i]); end
            end
            checks++; if (dv_cyc[b+1] - dv_cyc[b] !== TO + 2) begin errors++; $display("FAIL tie_spacing: got %0d want %0d", dv_cyc[b+1] - dv_cyc[b], TO + 2); end
        end
    endtask

    task automatic test_random();
        logic [7:0] f[NF];
        logic [7:0] ty;
        logic [31:0] p;
        int t, b, d0;
        bit ok;
        rand_ack = 1'b1; no_ack_idx = -1;
        for (int n = 0; n < 4; n++) begin
            ty = 8'($urandom); p = $urandom;
            build_frame(ty, p, f);
            b = dv_q.size(); d0 = done_cyc.size();
            frame_base = b;
            do_send(ty, p, t);
            wait_idle(600, ok);
            repeat (2) @(negedge clk);
            checks++; if (!ok) begin errors++; $display("FAIL rand%0d_idle: busy never dropped, required within 600 cycles", n); end
            checks++; if (dv_q.size() - b !== NF) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", n, dv_q.size() - b, NF); end
            else begin
                for (int i = 0; i < NF; i++) begin
                    checks++; if (dv_q[b+i] !== f[i]) begin errors++; $display("FAIL rand%0d_byte%0d: got %h want %h", n, i, dv_q[b+i], f[i]); end
                end
            end
            checks++; if (done_cyc.size() - d0 !== 1) begin errors++; $display("FAIL rand%0d_done: got %0d want 1", n, done_cyc.size() - d0); end
        end
        rand_ack = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_drop();
        test_timeout();
        test_reset_mid();
        test_tie();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
